// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate cache sitting between
// the CPU and sram_controller; misses fetch a 64-bit block, writes always go to SRAM.
module cache_controller #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en_in,
  input  logic        w_en_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  output logic        sram_r_en_out,
  output logic        sram_w_en_out,
  output logic [31:0] sram_address_out,
  output logic [31:0] sram_write_data_out,
  input  logic [63:0] sram_read_data_in,
  input  logic        sram_ready_in
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE_THROUGH
  } state_t;

  state_t state_q, state_d;

  logic                  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;

  assign word_sel = address_in[0];
  assign index    = address_in[INDEX_BITS:1];
  assign tag      = address_in[INDEX_BITS+TAG_BITS:INDEX_BITS+1];

  logic [SETS-1:0]     valid0_q, valid1_q, lru_q;
  logic [TAG_BITS-1:0] tag0_q  [SETS];
  logic [TAG_BITS-1:0] tag1_q  [SETS];
  logic [63:0]         data0_q [SETS];
  logic [63:0]         data1_q [SETS];

  logic        hit0, hit1, hit;
  logic [63:0] hit_block;

  assign hit0      = valid0_q[index] && (tag0_q[index] == tag);
  assign hit1      = valid1_q[index] && (tag1_q[index] == tag);
  assign hit       = hit0 || hit1;
  assign hit_block = hit1 ? data1_q[index] : data0_q[index];

  function automatic logic [31:0] pick_word(input logic [63:0] blk, input logic sel);
    return sel ? blk[63:32] : blk[31:0];
  endfunction

  // touch_en marks the hit way as recently used; word_wr_en patches it on a write hit
  logic touch_en, word_wr_en, fill_en;

  assign sram_r_en_out = (state_q == READ_MISS);
  assign sram_w_en_out = (state_q == WRITE_THROUGH);

  always_comb begin
    state_d             = state_q;
    ready_out           = 1'b0;
    read_data_out       = 32'h0;
    sram_address_out    = 32'h0;
    sram_write_data_out = 32'h0;
    touch_en            = 1'b0;
    word_wr_en          = 1'b0;
    fill_en             = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_en_in) begin
          state_d = WRITE_THROUGH;
          if (hit) begin
            touch_en   = 1'b1;
            word_wr_en = 1'b1;
          end
        end else if (r_en_in) begin
          if (hit) begin
            ready_out     = 1'b1;
            read_data_out = pick_word(hit_block, word_sel);
            touch_en      = 1'b1;
          end else begin
            state_d = READ_MISS;
          end
        end else begin
          ready_out = 1'b1;
        end
      end
      READ_MISS: begin
        sram_address_out = {address_in[31:1], 1'b0};
        if (sram_ready_in) begin
          ready_out     = 1'b1;
          read_data_out = pick_word(sram_read_data_in, word_sel);
          fill_en       = 1'b1;
          state_d       = IDLE;
        end
      end
      WRITE_THROUGH: begin
        sram_address_out    = address_in;
        sram_write_data_out = write_data_in;
        if (sram_ready_in) begin
          ready_out = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // LRU bit names the way to replace next, so it always points away from the last way used
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (touch_en) lru_q[index] <= ~hit1;
      if (fill_en) begin
        if (lru_q[index]) valid1_q[index] <= 1'b1;
        else              valid0_q[index] <= 1'b1;
        lru_q[index] <= ~lru_q[index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      if (lru_q[index]) begin
        data1_q[index] <= sram_read_data_in;
        tag1_q[index]  <= tag;
      end else begin
        data0_q[index] <= sram_read_data_in;
        tag0_q[index]  <= tag;
      end
    end
    if (!rst && word_wr_en) begin
      if (hit1) begin
        if (word_sel) data1_q[index][63:32] <= write_data_in;
        else          data1_q[index][31:0]  <= write_data_in;
      end else begin
        if (word_sel) data0_q[index][63:32] <= write_data_in;
        else          data0_q[index][31:0]  <= write_data_in;
      end
    end
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter INDEX_BITS, default 6, number of set-index bits (64 sets).
REQ-002 Parameter TAG_BITS, default 10, number of stored tag bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 r_en_in  input  1  CPU read request; held until ready_out.
REQ-006 w_en_in  input  1  CPU write request; held until ready_out.
REQ-007 address_in  input  32  CPU word address.
REQ-008 write_data_in  input  32  CPU write data.
REQ-009 read_data_out  output  32  CPU read data, valid when ready_out=1 with r_en_in=1.
REQ-010 ready_out  output  1  request complete; CPU pipeline freezes while 0.
REQ-011 sram_r_en_out  output  1  block read request to sram_controller.
REQ-012 sram_w_en_out  output  1  word write request to sram_controller.
REQ-013 sram_address_out  output  32  word address to sram_controller.
REQ-014 sram_write_data_out  output  32  write data to sram_controller.
REQ-015 sram_read_data_in  input  64  block from sram_controller; word at even address in [31:0], odd in [63:32].
REQ-016 sram_ready_in  input  1  one-cycle completion pulse from sram_controller.

Function
REQ-017 Address split: bit[0] word select, bits[INDEX_BITS:1] index, next TAG_BITS bits tag; higher bits ignored.
REQ-018 Storage: 2 ways per set, each with valid bit, tag, 64-bit data; one LRU bit per set naming the way to replace.
REQ-019 FSM states IDLE, READ_MISS, WRITE_THROUGH.
REQ-020 Hit = valid and tag match in either way; both ways never hold the same valid tag.
REQ-021 No request in IDLE: ready_out=1, SRAM enables 0, no state change.
REQ-022 Read hit in IDLE: ready_out=1 combinationally same cycle, read_data_out = selected word of hit way; at edge LRU set to the other way; stay IDLE.
REQ-023 Read miss in IDLE: ready_out=0; next state READ_MISS.
REQ-024 READ_MISS: sram_r_en_out=1, sram_address_out={address_in[31:1],1'b0}; ready_out=0 until sram_ready_in.
REQ-025 READ_MISS with sram_ready_in=1: ready_out=1 same cycle, read_data_out = selected word of sram_read_data_in; at edge fill way named by LRU (data, tag, valid=1), flip LRU, go IDLE.
REQ-026 Write in IDLE: next state WRITE_THROUGH; ready_out=0; if hit, at that edge hit way's selected word updated and LRU set to other way; miss: no allocation, no cache change.
REQ-027 WRITE_THROUGH: sram_w_en_out=1, sram_address_out=address_in, sram_write_data_out=write_data_in; on sram_ready_in: ready_out=1 same cycle, go IDLE.
REQ-028 SRAM enables are Moore outputs of state; both never asserted together; deassert the cycle after sram_ready_in.
REQ-029 r_en_in and w_en_in both high: write takes priority; read ignored.
REQ-030 sram_ready_in outside READ_MISS/WRITE_THROUGH ignored.
REQ-031 Inputs assumed stable while ready_out=0; no internal request latching.

Reset
REQ-032 rst=1 at edge: all valid bits 0, all LRU bits 0 (way 0 replaced first), state IDLE; data/tag arrays need not clear.
REQ-033 Reset mid-miss or mid-write abandons transaction; enables 0 the cycle after reset edge; no fill performed.
REQ-034 Outputs after reset: sram_r_en_out=0, sram_w_en_out=0, ready_out=1 if no request.

Verification
REQ-035 After reset, read 0x0, SRAM returns 64'h7788_5566_3344_1122 -> sram_r_en_out=1 with address 0x0 from next cycle; ready_out with sram_ready_in; read_data_out=0x33441122.
REQ-036 Then read 0x1 -> hit, ready_out=1 same cycle, read_data_out=0x77885566, sram_r_en_out stays 0.
REQ-037 Write 0x1 data 0xAABBCCDD -> sram_w_en_out=1, address 0x1, data 0xAABBCCDD until sram_ready_in; then read 0x1 hits returning 0xAABBCCDD.
REQ-038 Reads 0x0, 0x80, 0x100 (index 0, tags 0/1/2) -> third misses and evicts tag 0; then read 0x80 hits, read 0x0 misses.
REQ-039 Write miss 0x200 -> SRAM write issued, no allocation; subsequent read 0x200 misses.
REQ-040 rst asserted while READ_MISS waiting -> sram_r_en_out=0 next cycle; later read of same address misses again.
